mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch stage (IF) and the MEM stage.
- Sits between the fetch/mem stage logic and the unified memory. It sequences one transaction at a time and returns a one-cycle done pulse per request.
- The stages use done to drive their ready_go into the valid/allow_in pipeline handshakes.
- MEM has priority. A starvation counter guarantees IF forward progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width is DATA_W/8
STARVE_MAX, 4, max consecutive MEM grants while if_req is pending before IF is forced; must be >= 1; counter width clog2(STARVE_MAX+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
if_req  in  1  fetch request; held with if_addr stable until if_done
if_addr  in  ADDR_W  fetch address
if_flush  in  1  kill current/pending fetch (branch redirect)
if_done  out  1  one-cycle pulse, fetch data valid
if_rdata  out  DATA_W  fetch data, registered, held until next if_done
mem_req  in  1  data request; held with fields stable until mem_done
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_wstrb  in  DATA_W/8  byte strobes
mem_done  out  1  one-cycle pulse, load data valid or store acknowledged
mem_rdata  out  DATA_W  load data, registered, held until next mem_done
bus_req  out  1  bus request, registered
bus_we, bus_addr, bus_wdata, bus_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered; stable while bus_req=1
bus_gnt  in  1  bus accepts request in the cycle bus_req&&bus_gnt
bus_rvalid  in  1  response valid (load data or write ack)
bus_rdata  in  DATA_W  response data

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, owner=NONE, drop=0, starve_cnt=0.
  - All outputs 0, including rdata registers.
  - Reset mid-transaction abandons it; the bus is reset together with the arbiter.
- States:
  - IDLE: no transaction.
  - REQ: bus_req=1, waiting for bus_gnt.
  - RESP: bus_req=0, waiting for bus_rvalid.
- At most one outstanding bus transaction.
- IDLE arbitration (per cycle):
  - If mem_req && (!if_req_eff || starve_cnt<STARVE_MAX): choose MEM.
  - Else if if_req_eff: choose IF.
  - if_req_eff = if_req && !if_flush.
  - On a choice: latch bus_* from the winner (IF: we=0, wstrb=0, wdata=0), set owner, go to REQ. bus_req=1 from the next cycle.
- REQ:
  - bus_gnt=1: bus_req<=0, go to RESP.
  - Otherwise hold all bus_* unchanged.
- RESP:
  - bus_rvalid=1: capture bus_rdata into the owner's rdata register (stores also update mem_rdata with bus_rdata).
  - Pulse the owner's done the next cycle, unless owner=IF && drop.
  - Go to IDLE; clear drop and owner.
- bus_rvalid outside RESP is ignored.
- Minimum latency:
  - req sampled at cycle 0 -> bus_req at cycle 1 -> gnt at cycle 1 -> rvalid at cycle 2 -> done at cycle 3.
  - Next request can reach the bus at cycle 4 (IDLE at cycle 3, bus_req at cycle 4).
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each MEM choice made while if_req_eff=1.
  - Clears on an IF choice, and in any IDLE cycle with if_req_eff=0.
- Flush:
  - if_flush=1 while owner=IF in REQ or RESP sets drop=1. The transaction still completes on the bus (no request withdrawal), and if_done is suppressed. if_rdata is not updated.
  - if_flush in IDLE blocks IF selection that cycle.
  - if_flush does not affect MEM transactions.
- Simultaneous events:
  - if_flush in the same cycle as bus_rvalid for an IF response: the response is dropped.
  - done and a new IDLE arbitration occur in the same cycle. Requesters see done while still asserting req. They deassert or change req the cycle after done; the arbiter does not re-sample the completed requester until it is back in IDLE with state cleared. This means done for owner X blocks re-selection of X in that cycle.
- if_done and mem_done are never both 1.

Test Plan:
- Single load: mem_req, addr=0x100, we=0; bus_gnt immediate, rvalid 1 cycle later with rdata=0xDEADBEEF -> bus_addr=0x100 at cycle 1, mem_done=1 and mem_rdata=0xDEADBEEF at cycle 3, if_done stays 0.
- Store with delayed grant: mem_we=1, addr=0x204, wdata=0x12345678, wstrb=0xF; bus_gnt held low 3 cycles -> bus_* stable all 4 cycles of bus_req, one mem_done pulse after rvalid.
- Starvation: if_req and mem_req held continuously, STARVE_MAX=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM,... with starve_cnt back to 0 after the IF grant.
- Flush in RESP: IF fetch at 0x80 granted, if_flush pulsed before rvalid -> bus completes, if_done never pulses, if_rdata keeps its old value, next request accepted normally.
- Reset mid-RESP: reset=0 while waiting for rvalid -> bus_req, if_done, mem_done, rdata all 0 immediately (async), state IDLE after release. A stale bus_rvalid after release is ignored.
- Flush in IDLE with if_req=1 and mem_req=0 -> no bus_req the next cycle; fetch issued the cycle after if_flush deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between the fetch (IF) and MEM stages.
// MEM has priority; a saturating starvation counter forces an IF grant after STARVE_MAX MEM wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [(DATA_W/8)-1:0] mem_wstrb,
  output logic                  mem_done,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [(DATA_W/8)-1:0] bus_wstrb,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t              state, state_nxt;
  owner_t              owner, owner_nxt;
  logic                drop, drop_nxt;
  logic [CNT_W-1:0]    starve_cnt, starve_nxt;
  logic                if_done_nxt, mem_done_nxt, bus_req_nxt, bus_we_nxt;
  logic [DATA_W-1:0]   if_rdata_nxt, mem_rdata_nxt, bus_wdata_nxt;
  logic [ADDR_W-1:0]   bus_addr_nxt;
  logic [STRB_W-1:0]   bus_wstrb_nxt;

  logic if_req_eff, starved, mem_win, if_win, pick_mem, pick_if;

  // The raw winner is computed first; a winner that is being handed its done this
  // cycle is still presenting its stale request, so nobody is granted that cycle.
  assign if_req_eff = if_req && !if_flush;
  assign starved    = starve_cnt >= CNT_W'(STARVE_MAX);
  assign mem_win    = mem_req && (!if_req_eff || !starved);
  assign if_win     = if_req_eff && !mem_win;
  assign pick_mem   = mem_win && !mem_done;
  assign pick_if    = if_win && !if_done;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      drop       <= 1'b0;
      starve_cnt <= '0;
      if_done    <= 1'b0;
      if_rdata   <= '0;
      mem_done   <= 1'b0;
      mem_rdata  <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      drop       <= drop_nxt;
      starve_cnt <= starve_nxt;
      if_done    <= if_done_nxt;
      if_rdata   <= if_rdata_nxt;
      mem_done   <= mem_done_nxt;
      mem_rdata  <= mem_rdata_nxt;
      bus_req    <= bus_req_nxt;
      bus_we     <= bus_we_nxt;
      bus_addr   <= bus_addr_nxt;
      bus_wdata  <= bus_wdata_nxt;
      bus_wstrb  <= bus_wstrb_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    drop_nxt      = drop;
    starve_nxt    = starve_cnt;
    if_done_nxt   = 1'b0;
    mem_done_nxt  = 1'b0;
    if_rdata_nxt  = if_rdata;
    mem_rdata_nxt = mem_rdata;
    bus_req_nxt   = bus_req;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    bus_wstrb_nxt = bus_wstrb;

    case (state)
      IDLE: begin
        if (!if_req_eff) starve_nxt = '0;
        if (pick_mem) begin
          state_nxt     = REQ;
          owner_nxt     = OWN_MEM;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = mem_we;
          bus_addr_nxt  = mem_addr;
          bus_wdata_nxt = mem_wdata;
          bus_wstrb_nxt = mem_wstrb;
          if (if_req_eff && !starved) starve_nxt = starve_cnt + CNT_W'(1);
        end else if (pick_if) begin
          state_nxt     = REQ;
          owner_nxt     = OWN_IF;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = 1'b0;
          bus_addr_nxt  = if_addr;
          bus_wdata_nxt = '0;
          bus_wstrb_nxt = '0;
          starve_nxt    = '0;
        end
      end
      REQ: begin
        if (owner == OWN_IF && if_flush) drop_nxt = 1'b1;
        if (bus_gnt) begin
          bus_req_nxt = 1'b0;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        if (owner == OWN_IF && if_flush) drop_nxt = 1'b1;
        if (bus_rvalid) begin
          if (owner == OWN_MEM) begin
            mem_rdata_nxt = bus_rdata;
            mem_done_nxt  = 1'b1;
          end else if (owner == OWN_IF && !drop && !if_flush) begin
            if_rdata_nxt = bus_rdata;
            if_done_nxt  = 1'b1;
          end
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
          drop_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expected responses,
// a monitor pops them on each done pulse; a bus model with its own memory answers requests.
module tb_mem_port_arbiter;

  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        if_done, mem_done, bus_req, bus_we;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] last_if_exp = '0;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] grant_log[$];

  int gmin = 0, gmax = 0, rmin = 0, rmax = 0;
  bit stale = 1'b0;
  int last_req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ack_val(input logic [31:0] a);
    return ~a ^ 32'h00FF_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rd_bus(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  // Bus model: random grant delay, random response delay, own backing memory
  initial begin
    bit in_req = 1'b0, rsp_pending = 1'b0;
    int gwait = 0, rsp_wait = 0, req_cycles = 0;
    logic [31:0] s_addr = '0, s_wdata = '0, rsp_data = '0;
    logic s_we = 1'b0;
    logic [3:0] s_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_req = 1'b0; rsp_pending = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      end else begin
        bus_rvalid = 1'b0;
        if (stale) begin
          bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0; stale = 1'b0;
        end else if (rsp_pending) begin
          if (rsp_wait == 0) begin
            bus_rvalid = 1'b1; bus_rdata = rsp_data; rsp_pending = 1'b0;
          end else rsp_wait--;
        end
        bus_gnt = 1'b0;
        if (bus_req) begin
          if (!in_req) begin
            in_req = 1'b1; req_cycles = 0;
            s_addr = bus_addr; s_wdata = bus_wdata; s_we = bus_we; s_wstrb = bus_wstrb;
            gwait = int'($urandom_range(gmax, gmin));
          end else begin
            chk("bus_hold_addr", bus_addr, s_addr);
            chk("bus_hold_wdata", bus_wdata, s_wdata);
            chk("bus_hold_ctl", {27'd0, bus_we, bus_wstrb}, {27'd0, s_we, s_wstrb});
          end
          req_cycles++;
          if (gwait == 0) begin
            bus_gnt = 1'b1; in_req = 1'b0; last_req_cycles = req_cycles;
            grant_log.push_back(s_addr);
            if (s_we) begin
              bus_mem[s_addr] = merge(rd_bus(s_addr), s_wdata, s_wstrb);
              rsp_data = ack_val(s_addr);
            end else rsp_data = rd_bus(s_addr);
            rsp_pending = 1'b1;
            rsp_wait = int'($urandom_range(rmax, rmin));
          end else gwait--;
        end
      end
    end
  end

  // Monitor: every done pulse pops the owner's expected response
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (if_done || mem_done) chk("done_exclusive", 32'(if_done && mem_done), 32'd0);
        if (if_done) begin
          if (if_q.size() == 0) fail_now("if_done_unexpected");
          else begin e = if_q.pop_front(); chk("if_rdata", if_rdata, e); last_if_exp = e; end
        end
        if (mem_done) begin
          if (mem_q.size() == 0) fail_now("mem_done_unexpected");
          else begin e = mem_q.pop_front(); chk("mem_rdata", mem_rdata, e); end
        end
      end
    end
  end

  task automatic if_fetch(input logic [31:0] a, input int gap, input int flush_pct);
    int c = 0;
    bit fin = 1'b0, flushed = 1'b0;
    if_req = 1'b1; if_addr = a; if_q.push_back(rd_ref(a));
    while (!fin && c < BUDGET) begin
      @(negedge clk); c++;
      if (if_done) fin = 1'b1;
      else if (flush_pct > 0 && int'($urandom_range(99, 0)) < flush_pct) begin
        if_flush = 1'b1; if_req = 1'b0; if_q.delete();
        @(negedge clk);
        if_flush = 1'b0; fin = 1'b1; flushed = 1'b1;
      end
    end
    if (!fin) begin fail_now("if_done_timeout"); if_q.delete(); end
    else if (!flushed) @(negedge clk);
    if_req = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic mem_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input int gap);
    int c = 0;
    bit fin = 1'b0;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    if (we) begin
      ref_mem[a] = merge(rd_ref(a), wd, ws);
      mem_q.push_back(ack_val(a));
    end else mem_q.push_back(rd_ref(a));
    while (!fin && c < BUDGET) begin
      @(negedge clk); c++;
      if (mem_done) fin = 1'b1;
    end
    if (!fin) begin fail_now("mem_done_timeout"); mem_q.delete(); end
    else @(negedge clk);
    mem_req = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_bus_req(input string name);
    int c = 0;
    while (!bus_req && c < BUDGET) begin @(negedge clk); c++; end
    if (!bus_req) fail_now(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single load with immediate grant and one-cycle response
    ref_mem[32'h100] = 32'hDEAD_BEEF; bus_mem[32'h100] = 32'hDEAD_BEEF;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_wdata = '0; mem_wstrb = '0;
    mem_q.push_back(rd_ref(32'h100));
    @(negedge clk);
    chk("load_bus_req_c1", 32'(bus_req), 32'd1);
    chk("load_bus_addr_c1", bus_addr, 32'h100);
    @(negedge clk);
    chk("load_no_done_c2", 32'(mem_done), 32'd0);
    @(negedge clk);
    chk("load_done_c3", 32'(mem_done), 32'd1);
    chk("load_if_done_c3", 32'(if_done), 32'd0);
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);

    // Store held off by three cycles of no grant
    gmin = 3; gmax = 3; rmin = 1; rmax = 1;
    mem_access(1'b1, 32'h204, 32'h1234_5678, 4'hF, 1);
    chk("store_req_cycles", 32'(last_req_cycles), 32'd4);

    // Both requesters pending continuously: four MEM grants, then IF
    gmin = 0; gmax = 2; rmin = 0; rmax = 2;
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 2; i++) if_fetch(32'h40, 0, 0);
      end
      begin
        for (int i = 0; i < 8; i++) mem_access(1'b0, 32'h1000 + 32'(i * 4), '0, '0, 0);
      end
    join
    chk("starve_grants", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < grant_log.size() && i < 10; i++)
      chk($sformatf("starve_order_%0d", i), 32'(grant_log[i] >= 32'h1000),
          (i % 5 == 4) ? 32'd0 : 32'd1);
    repeat (2) @(negedge clk);

    // Flush while the fetch waits for its response
    gmin = 0; gmax = 0; rmin = 3; rmax = 3;
    if_req = 1'b1; if_addr = 32'h80;
    wait_bus_req("flush_resp_bus_req");
    @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (if_done) cnt++; end
    chk("flush_resp_no_done", 32'(cnt), 32'd0);
    chk("flush_resp_rdata_kept", if_rdata, last_if_exp);
    rmin = 0; rmax = 1;
    if_fetch(32'h84, 1, 0);

    // Flush in IDLE blocks the pending fetch for that cycle only
    gmin = 0; gmax = 0;
    if_req = 1'b1; if_addr = 32'h44; if_flush = 1'b1;
    if_q.push_back(rd_ref(32'h44));
    @(negedge clk);
    chk("idle_flush_no_req", 32'(bus_req), 32'd0);
    if_flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_req_after", 32'(bus_req), 32'd1);
    chk("idle_flush_addr", bus_addr, 32'h44);
    chk("if_fields_zero", bus_wdata | {27'd0, bus_we, bus_wstrb}, 32'd0);
    cnt = 0;
    while (!if_done && cnt < BUDGET) begin @(negedge clk); cnt++; end
    if (!if_done) fail_now("idle_flush_done_timeout");
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset while waiting for a response, then a stale rvalid
    rmin = 6; rmax = 6;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1040; mem_wdata = '0; mem_wstrb = '0;
    wait_bus_req("reset_bus_req");
    @(negedge clk);
    reset = 1'b0; mem_req = 1'b0;
    #1;
    chk("arst_bus_req", 32'(bus_req), 32'd0);
    chk("arst_if_done", 32'(if_done), 32'd0);
    chk("arst_mem_done", 32'(mem_done), 32'd0);
    chk("arst_if_rdata", if_rdata, 32'd0);
    chk("arst_mem_rdata", mem_rdata, 32'd0);
    last_if_exp = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stale = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stale_rvalid_ignored", {29'd0, bus_req, if_done, mem_done}, 32'd0);
    end
    rmin = 0; rmax = 2;
    mem_access(1'b0, 32'h1040, '0, '0, 0);

    // Randomised traffic from both stages with random flushes and bus delays
    gmin = 0; gmax = 3; rmin = 0; rmax = 3;
    fork
      begin
        for (int i = 0; i < 40; i++)
          if_fetch(32'($urandom_range(1023, 0)) << 2, int'($urandom_range(3, 0)), 10);
      end
      begin
        for (int i = 0; i < 40; i++)
          mem_access(1'($urandom_range(1, 0)), 32'h1000 + (32'($urandom_range(63, 0)) << 2),
                     $urandom, 4'($urandom_range(15, 1)), int'($urandom_range(3, 0)));
      end
    join
    repeat (10) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
